regfile_dump_reader: RTL

//   Post-run register-file dump engine for the single-cycle RISC-V core.
//   On a rising edge of finish_flag it walks x0..x(NUM_REGS-1) through a spare

---
 rtl/regfile_dump_reader.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Post-run register-file dump engine: walks x0..x(NUM_REGS-1) through a spare RF read port
// and streams {index, value} beats on valid/ready. Define REGDUMP_SKIP_ZERO_EN to drop zero regs.
module regfile_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish_flag,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              finish_q;
  logic              dump_valid_q;
  logic [ADDR_W-1:0] dump_index_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              dump_last_q;
  logic              busy_q;
  logic              done_q;

  logic trig;
  logic is_last;
  logic skip;

  assign trig    = finish_flag & ~finish_q;
  assign is_last = (idx_q == LastIdx);

`ifdef REGDUMP_SKIP_ZERO_EN
  // The final register is always emitted so the sink always sees dump_last.
  assign skip = (rf_data == '0) && !is_last;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      finish_q     <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_index_q <= '0;
      dump_data_q  <= '0;
      dump_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      finish_q <= finish_flag;
      unique case (state_q)
        StIdle: begin
          if (trig) begin
            state_q <= StRead;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StRead: begin
          if (skip) begin
            idx_q <= idx_q + ADDR_W'(1);
          end else begin
            dump_data_q  <= rf_data;
            dump_index_q <= idx_q;
            dump_last_q  <= is_last;
            dump_valid_q <= 1'b1;
            state_q      <= StSend;
          end
        end
        StSend: begin
          // Payload registers are untouched here, so they stay stable under backpressure.
          if (dump_ready) begin
            dump_valid_q <= 1'b0;
            if (dump_last_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          if (!finish_flag) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rf_addr    = idx_q;
  assign dump_valid = dump_valid_q;
  assign dump_index = dump_index_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
